pc_unit: RTL and testbench

//   Program-counter register and return-address stack for the multi-cycle processor.

---
 rtl/pc_unit.sv | 65 ++++++
 tb/tb_pc_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: program counter register with a CALL/RET return-address stack
module pc_unit #(
    parameter int ADDR_W = 16,
    parameter int IMM_W = 10,
    parameter int DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_write,
    input  logic [1:0]        pc_src,
    input  logic [IMM_W-1:0]  imm,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              call,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] stack_top,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = AW + 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [SW-1:0]     sp;
    logic [AW-1:0]     top_idx;
    logic [ADDR_W-1:0] pc_inc, pc_next;
    logic              is_call, is_ret, push, pop, err_set;

    // stack status and next-PC selection from the registered pc/sp
    always_comb begin
        stack_empty = sp == '0;
        stack_full = sp == SW'(DEPTH);
        top_idx = sp[AW-1:0] - AW'(1);
        stack_top = stack_empty ? '0 : mem[top_idx];
        pc_inc = pc + ADDR_W'(1);
        is_call = pc_src == 2'b10 && call;
        is_ret = pc_src == 2'b11;
        push = pc_write && is_call && !stack_full;
        pop = pc_write && is_ret && !stack_empty;
        err_set = pc_write && ((is_call && stack_full) || (is_ret && (stack_empty || call)));
        pc_next = pc_src == 2'b00 ? pc_inc :
                  pc_src == 2'b01 ? pc + {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm} :
                  pc_src == 2'b10 ? jump_addr :
                  stack_empty ? pc_inc : stack_top;
    end

    // pc, stack pointer and sticky error commit only on pc_write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
            sp <= '0;
            stack_err <= 1'b0;
        end else if (pc_write) begin
            pc <= pc_next;
            sp <= push ? sp + SW'(1) : pop ? sp - SW'(1) : sp;
            if (err_set) stack_err <= 1'b1;
        end
    end

    // return-address storage; contents are not reset
    always_ff @(posedge clk) begin
        if (rst_n && push) mem[sp[AW-1:0]] <= pc_inc;
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit with a reference stack model
module tb_pc_unit;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        pc_write = 0;
    logic [1:0]  pc_src = 0;
    logic [9:0]  imm = 0;
    logic [15:0] jump_addr = 0;
    logic        call = 0;
    logic [15:0] pc, stack_top;
    logic        stack_empty, stack_full, stack_err;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] m_pc = 0;
    logic [15:0] m_stk[8];
    int          m_sp = 0;
    logic        m_err = 0;

    pc_unit dut (
        .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .pc_src(pc_src),
        .imm(imm), .jump_addr(jump_addr), .call(call), .pc(pc),
        .stack_top(stack_top), .stack_empty(stack_empty),
        .stack_full(stack_full), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_flags();
        check("stack_empty", 16'(stack_empty), 16'(m_sp == 0));
        check("stack_full", 16'(stack_full), 16'(m_sp == 8));
        check("stack_err", 16'(stack_err), 16'(m_err));
        check("stack_top", stack_top, m_sp == 0 ? 16'h0 : m_stk[m_sp-1]);
    endtask

    task automatic step(input logic [1:0] s, input logic [9:0] i, input logic [15:0] j, input logic c);
        logic [15:0] np;
        @(negedge clk);
        pc_write = 1; pc_src = s; imm = i; jump_addr = j; call = c;
        np = m_pc + 16'd1;
        if (s == 2'b01) np = m_pc + {{6{i[9]}}, i};
        if (s == 2'b10) begin
            np = j;
            if (c) begin
                if (m_sp == 8) m_err = 1;
                else begin m_stk[m_sp] = m_pc + 16'd1; m_sp++; end
            end
        end
        if (s == 2'b11) begin
            if (c) m_err = 1;
            if (m_sp == 0) m_err = 1;
            else begin m_sp--; np = m_stk[m_sp]; end
        end
        m_pc = np;
        exp_q.push_back(np);
        @(posedge clk);
        #1;
        pc_write = 0; call = 0;
        check("pc", pc, exp_q.pop_front());
        check_flags();
    endtask

    task automatic hold(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            pc_src = 2'b01; imm = 10'h3FC; call = 1; jump_addr = 16'hBEEF;
            exp_q.push_back(m_pc);
            @(posedge clk);
            #1;
            check("hold_pc", pc, exp_q.pop_front());
        end
        call = 0;
    endtask

    initial begin
        #12;
        check("rst_pc", pc, 16'h0000);
        check_flags();
        @(negedge clk);
        rst_n = 1;
        hold(5);
        step(2'b10, 10'h0, 16'h0010, 0);
        step(2'b01, 10'h3FC, 16'h0, 0);
        check("branch_neg", pc, 16'h000C);
        step(2'b01, 10'h005, 16'h0, 0);
        check("branch_pos", pc, 16'h0011);
        step(2'b10, 10'h0, 16'h0020, 0);
        step(2'b10, 10'h0, 16'h0100, 1);
        check("call_top", stack_top, 16'h0021);
        step(2'b11, 10'h0, 16'h0, 0);
        check("ret_pc", pc, 16'h0021);
        step(2'b11, 10'h0, 16'h0, 1);
        step(2'b10, 10'h0, 16'h0200, 0);
        for (int k = 0; k < 8; k++) step(2'b10, 10'h0, 16'h1000 + 16'(k * 16), 1);
        check("full", 16'(stack_full), 16'h1);
        step(2'b10, 10'h0, 16'h2000, 1);
        check("ovf_pc", pc, 16'h2000);
        for (int k = 0; k < 8; k++) step(2'b11, 10'h0, 16'h0, 0);
        check("lifo_last", pc, 16'h0201);
        step(2'b10, 10'h0, 16'h0040, 0);
        step(2'b11, 10'h0, 16'h0, 0);
        check("ret_empty", pc, 16'h0041);
        step(2'b10, 10'h0, 16'hFFFF, 0);
        step(2'b00, 10'h0, 16'h0, 0);
        check("wrap", pc, 16'h0000);
        for (int k = 0; k < 3; k++) step(2'b10, 10'h0, 16'h0300 + 16'(k), 1);
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        m_pc = 0; m_sp = 0; m_err = 0;
        check("async_pc", pc, 16'h0000);
        check_flags();
        @(negedge clk);
        rst_n = 1;
        step(2'b00, 10'h0, 16'h0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
